// File: rtl/axi4_full_slave_mem_pkg.sv
// Shared types and constants for the AXI4 full slave memory.
package axi4_full_slave_mem_pkg;

    // Write channel FSM states.
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Read channel FSM states.
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int BYTE_W = 8;

    // A burst is only OKAY when WLAST arrives exactly on the final counted beat.
    function automatic logic [1:0] burst_resp(input logic last_on_final_beat);
        return last_on_final_beat ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi4_slave_mem_array.sv
// Byte-lane word memory: one byte-enabled write port, one registered read port.
// A read and write of the same word in one cycle returns the old contents.
module axi4_slave_mem_array
    import axi4_full_slave_mem_pkg::*;
#(
    parameter int WORD_ADDR_W = 8,
    parameter int DATA_W      = 32
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [WORD_ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W/8-1:0]     wr_strb,
    input  logic                    rd_en,
    input  logic [WORD_ADDR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0]       rd_data
);

    localparam int DEPTH = 1 << WORD_ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / BYTE_W; gi++) begin : g_lane
            logic [BYTE_W-1:0] lane_mem [DEPTH];
            logic [BYTE_W-1:0] lane_rd_reg;

            // Per-lane storage; the read register only advances when asked so
            // the read data holds during back-pressure.
            always_ff @(posedge clk) begin
                if (wr_en && wr_strb[gi]) begin
                    lane_mem[wr_addr] <= wr_data[gi*BYTE_W +: BYTE_W];
                end
                if (rd_en) begin
                    lane_rd_reg <= lane_mem[rd_addr];
                end
            end

            assign rd_data[gi*BYTE_W +: BYTE_W] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/axi4_full_slave_mem.sv
// AXI4 (INCR-only, 32-bit) slave backed by a 256-word memory.
// Independent write and read FSMs share the memory array.
module axi4_full_slave_mem
    import axi4_full_slave_mem_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int WA = C_S_AXI_ADDR_WIDTH - 2;

    // ---------------- write channel ----------------
    wr_state_t         w_state_reg, w_state_next;
    logic [WA-1:0]     w_addr_reg, w_addr_next;
    logic [7:0]        w_len_reg, w_len_next;
    logic [7:0]        w_cnt_reg, w_cnt_next;
    logic [1:0]        bresp_reg, bresp_next;
    logic              awready_reg, wready_reg, bvalid_reg;
    logic              w_hs;

    assign w_hs = wready_reg && S_AXI_WVALID;

    // Write next-state: latch burst on AW, step address per beat, end on
    // counted last beat or early WLAST, hold response until accepted.
    always_comb begin
        w_state_next = w_state_reg;
        w_addr_next  = w_addr_reg;
        w_len_next   = w_len_reg;
        w_cnt_next   = w_cnt_reg;
        bresp_next   = bresp_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (awready_reg && S_AXI_AWVALID) begin
                    w_addr_next  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    w_len_next   = S_AXI_AWLEN;
                    w_cnt_next   = 8'd0;
                    w_state_next = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    w_addr_next = w_addr_reg + WA'(1);
                    w_cnt_next  = w_cnt_reg + 8'd1;
                    if ((w_cnt_reg == w_len_reg) || S_AXI_WLAST) begin
                        bresp_next   = burst_resp((w_cnt_reg == w_len_reg) && S_AXI_WLAST);
                        w_state_next = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_reg && S_AXI_BREADY) begin
                    bresp_next   = RESP_OKAY;
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write state register; handshake flags are registered decodes of the next state.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_reg <= W_IDLE;
            w_addr_reg  <= '0;
            w_len_reg   <= 8'd0;
            w_cnt_reg   <= 8'd0;
            bresp_reg   <= RESP_OKAY;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            w_addr_reg  <= w_addr_next;
            w_len_reg   <= w_len_next;
            w_cnt_reg   <= w_cnt_next;
            bresp_reg   <= bresp_next;
            awready_reg <= (w_state_next == W_IDLE);
            wready_reg  <= (w_state_next == W_DATA);
            bvalid_reg  <= (w_state_next == W_RESP);
        end
    end

    // ---------------- read channel ----------------
    rd_state_t         r_state_reg, r_state_next;
    logic [WA-1:0]     r_addr_reg, r_addr_next;
    logic [7:0]        r_len_reg, r_len_next;
    logic [7:0]        r_cnt_reg, r_cnt_next;
    logic              rlast_reg, rlast_next;
    logic              arready_reg, rvalid_reg;
    logic              rd_en;
    logic [WA-1:0]     rd_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] mem_rd_data;

    // Read next-state: the memory fetch for the next beat is issued on the
    // edge that completes the current handshake, so beats stream one per cycle.
    always_comb begin
        r_state_next = r_state_reg;
        r_addr_next  = r_addr_reg;
        r_len_next   = r_len_reg;
        r_cnt_next   = r_cnt_reg;
        rlast_next   = rlast_reg;
        rd_en        = 1'b0;
        rd_addr      = r_addr_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (arready_reg && S_AXI_ARVALID) begin
                    rd_en        = 1'b1;
                    rd_addr      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    r_addr_next  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2] + WA'(1);
                    r_len_next   = S_AXI_ARLEN;
                    r_cnt_next   = 8'd0;
                    rlast_next   = (S_AXI_ARLEN == 8'd0);
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_reg && S_AXI_RREADY) begin
                    if (rlast_reg) begin
                        rlast_next   = 1'b0;
                        r_state_next = R_IDLE;
                    end else begin
                        rd_en       = 1'b1;
                        r_addr_next = r_addr_reg + WA'(1);
                        r_cnt_next  = r_cnt_reg + 8'd1;
                        rlast_next  = ((r_cnt_reg + 8'd1) == r_len_reg);
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_reg <= R_IDLE;
            r_addr_reg  <= '0;
            r_len_reg   <= 8'd0;
            r_cnt_reg   <= 8'd0;
            rlast_reg   <= 1'b0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            r_addr_reg  <= r_addr_next;
            r_len_reg   <= r_len_next;
            r_cnt_reg   <= r_cnt_next;
            rlast_reg   <= rlast_next;
            arready_reg <= (r_state_next == R_IDLE);
            rvalid_reg  <= (r_state_next == R_DATA);
        end
    end

    axi4_slave_mem_array #(
        .WORD_ADDR_W (WA),
        .DATA_W      (C_S_AXI_DATA_WIDTH)
    ) u_mem (
        .clk     (ACLK),
        .wr_en   (w_hs),
        .wr_addr (w_addr_reg),
        .wr_data (S_AXI_WDATA),
        .wr_strb (S_AXI_WSTRB),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (mem_rd_data)
    );

    // Address byte-offset bits are ignored: only whole-word beats exist.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RLAST   = rlast_reg;
    assign S_AXI_RRESP   = RESP_OKAY;
    // Gating by RVALID makes RDATA read zero whenever no beat is presented,
    // including immediately on reset assertion.
    assign S_AXI_RDATA   = rvalid_reg ? mem_rd_data : '0;

endmodule

// File: tb/tb_axi4_full_slave_mem.sv
// Self-checking bench for axi4_full_slave_mem: table of bursts plus
// hand-written concurrency and reset sequences, reads checked via a scoreboard.
module tb_axi4_full_slave_mem;

    logic        ACLK;
    logic        ARESETN;
    logic [9:0]  S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [9:0]  S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    axi4_full_slave_mem #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (10)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [256];

    typedef struct {
        logic [31:0] data;
        logic        last;
    } rbeat_t;
    rbeat_t exp_q [$];

    typedef struct {
        bit          is_read;
        logic [9:0]  addr;
        logic [7:0]  len;
        int          nbeats;
        logic [31:0] data0;
        logic [31:0] dstep;
        logic [3:0]  strb;
        int          wlast_beat;
        logic [1:0]  bresp;
        int          stall_beat;
        int          stall_cycles;
    } vec_t;
    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return S_AXI_AWREADY;
            1:       return S_AXI_WREADY;
            2:       return S_AXI_BVALID;
            3:       return S_AXI_ARREADY;
            default: return S_AXI_RVALID;
        endcase
    endfunction

    // Wait (bounded) until the selected DUT flag is high; called at posedge+1.
    task automatic wait_high(input int sel, input string name);
        int n = 0;
        while (!sig(sel) && n < 50) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: got 0 expected 1 within 50 cycles", name);
        end
    endtask

    task automatic model_write(input int word, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) model_mem[word % 256][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic push_expected(input logic [9:0] addr, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back('{model_mem[(int'(addr[9:2]) + i) % 256], (i == int'(len))});
        end
    endtask

    task automatic write_burst(input logic [9:0] addr, input logic [7:0] len, input int nbeats,
                               input logic [31:0] data0, input logic [31:0] dstep,
                               input logic [3:0] strb, input int wlast_beat, input logic [1:0] exp_bresp);
        S_AXI_AWADDR  = addr;
        S_AXI_AWLEN   = len;
        S_AXI_AWVALID = 1'b1;
        wait_high(0, "awready");
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            S_AXI_WDATA  = data0 + dstep * i;
            S_AXI_WSTRB  = strb;
            S_AXI_WLAST  = (i == wlast_beat);
            S_AXI_WVALID = 1'b1;
            wait_high(1, "wready");
            @(posedge ACLK); #1;
            model_write(int'(addr[9:2]) + i, data0 + dstep * i, strb);
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        wait_high(2, "bvalid");
        check("bresp", {30'd0, S_AXI_BRESP}, {30'd0, exp_bresp});
        check("wready_in_resp", {31'd0, S_AXI_WREADY}, 32'd0);
        repeat (2) begin
            @(posedge ACLK); #1;
        end
        check("bvalid_held", {31'd0, S_AXI_BVALID}, 32'd1);
        check("bresp_held", {30'd0, S_AXI_BRESP}, {30'd0, exp_bresp});
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        check("bvalid_clear", {31'd0, S_AXI_BVALID}, 32'd0);
        $display("write addr=0x%03h len=%0d beats=%0d bresp=%0b", addr, len, nbeats, exp_bresp);
    endtask

    // Issue a read; expected beats must already be queued in exp_q.
    task automatic read_burst(input logic [9:0] addr, input logic [7:0] len,
                              input int stall_beat, input int stall_cycles);
        int  beat  = 0;
        int  stall = 0;
        int  guard = 0;
        bit  hs;
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = len;
        S_AXI_ARVALID = 1'b1;
        wait_high(3, "arready");
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        check("rvalid_first", {31'd0, S_AXI_RVALID}, 32'd1);
        while (exp_q.size() > 0 && guard < 300) begin
            guard++;
            hs = 1'b0;
            if (S_AXI_RVALID) begin
                check("rdata", S_AXI_RDATA, exp_q[0].data);
                check("rlast", {31'd0, S_AXI_RLAST}, {31'd0, exp_q[0].last});
                check("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
                if (beat == stall_beat && stall < stall_cycles) begin
                    S_AXI_RREADY = 1'b0;
                    stall++;
                end else begin
                    S_AXI_RREADY = 1'b1;
                    hs = 1'b1;
                end
            end else begin
                S_AXI_RREADY = 1'b0;
            end
            @(posedge ACLK); #1;
            if (hs) begin
                void'(exp_q.pop_front());
                beat++;
            end
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL read_timeout: got %0d beats expected %0d", beat, beat + exp_q.size());
            exp_q.delete();
        end
        S_AXI_RREADY = 1'b0;
        check("rvalid_end", {31'd0, S_AXI_RVALID}, 32'd0);
        $display("read  addr=0x%03h len=%0d beats=%0d stall=%0d", addr, len, beat, stall);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, {31'd0, S_AXI_AWREADY}, 32'd0);
        check({tag, "_wready"},  {31'd0, S_AXI_WREADY},  32'd0);
        check({tag, "_bvalid"},  {31'd0, S_AXI_BVALID},  32'd0);
        check({tag, "_arready"}, {31'd0, S_AXI_ARREADY}, 32'd0);
        check({tag, "_rvalid"},  {31'd0, S_AXI_RVALID},  32'd0);
        check({tag, "_rlast"},   {31'd0, S_AXI_RLAST},   32'd0);
        check({tag, "_bresp"},   {30'd0, S_AXI_BRESP},   32'd0);
        check({tag, "_rresp"},   {30'd0, S_AXI_RRESP},   32'd0);
        check({tag, "_rdata"},   S_AXI_RDATA,            32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //         rd  addr     len nb data0         dstep         strb     wl bresp  sb sc
        vecs[0]  = '{0, 10'h010, 3, 4, 32'h11111111, 32'h11111111, 4'hF,    3, 2'b00, -1, 0};
        vecs[1]  = '{1, 10'h010, 3, 0, 32'h0,        32'h0,        4'h0,   -1, 2'b00, -1, 0};
        vecs[2]  = '{0, 10'h020, 0, 1, 32'h00000000, 32'h0,        4'hF,    0, 2'b00, -1, 0};
        vecs[3]  = '{0, 10'h020, 0, 1, 32'hAABBCCDD, 32'h0,        4'b0101, 0, 2'b00, -1, 0};
        vecs[4]  = '{1, 10'h020, 0, 0, 32'h0,        32'h0,        4'h0,   -1, 2'b00, -1, 0};
        vecs[5]  = '{0, 10'h3FC, 1, 2, 32'h5,        32'h1,        4'hF,    1, 2'b00, -1, 0};
        vecs[6]  = '{1, 10'h000, 0, 0, 32'h0,        32'h0,        4'h0,   -1, 2'b00, -1, 0};
        vecs[7]  = '{1, 10'h3FC, 0, 0, 32'h0,        32'h0,        4'h0,   -1, 2'b00, -1, 0};
        vecs[8]  = '{1, 10'h3FC, 1, 0, 32'h0,        32'h0,        4'h0,   -1, 2'b00, -1, 0};
        vecs[9]  = '{1, 10'h010, 3, 0, 32'h0,        32'h0,        4'h0,   -1, 2'b00,  1, 3};
        vecs[10] = '{0, 10'h040, 3, 2, 32'hC0DE0000, 32'h1,        4'hF,    1, 2'b10, -1, 0};
        vecs[11] = '{0, 10'h050, 1, 2, 32'hBEEF0000, 32'h1,        4'hF,   -1, 2'b10, -1, 0};
        vecs[12] = '{1, 10'h040, 1, 0, 32'h0,        32'h0,        4'h0,   -1, 2'b00, -1, 0};
        vecs[13] = '{1, 10'h050, 1, 0, 32'h0,        32'h0,        4'h0,   -1, 2'b00, -1, 0};

        ARESETN       = 1'b0;
        S_AXI_AWADDR  = '0;
        S_AXI_AWLEN   = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WLAST   = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARLEN   = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;

        // Reset state and release behaviour.
        #32;
        check_all_zero("reset");
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        check("awready_before_edge", {31'd0, S_AXI_AWREADY}, 32'd0);
        @(posedge ACLK); #1;
        check("awready_after_release", {31'd0, S_AXI_AWREADY}, 32'd1);
        check("arready_after_release", {31'd0, S_AXI_ARREADY}, 32'd1);

        // Table-driven bursts.
        for (int v = 0; v < 14; v++) begin
            if (vecs[v].is_read) begin
                push_expected(vecs[v].addr, vecs[v].len);
                read_burst(vecs[v].addr, vecs[v].len, vecs[v].stall_beat, vecs[v].stall_cycles);
            end else begin
                write_burst(vecs[v].addr, vecs[v].len, vecs[v].nbeats, vecs[v].data0,
                            vecs[v].dstep, vecs[v].strb, vecs[v].wlast_beat, vecs[v].bresp);
            end
        end

        // Literal expectations for strobe merge and address wrap.
        exp_q.push_back('{32'h00BB00DD, 1'b1});
        read_burst(10'h020, 8'd0, -1, 0);
        exp_q.push_back('{32'h00000006, 1'b1});
        read_burst(10'h000, 8'd0, -1, 0);
        exp_q.push_back('{32'h00000005, 1'b1});
        read_burst(10'h3FC, 8'd0, -1, 0);

        // Same-cycle write and read of one word returns pre-write data.
        write_burst(10'h060, 8'd0, 1, 32'h12345678, 32'h0, 4'hF, 0, 2'b00);
        S_AXI_AWADDR  = 10'h060;
        S_AXI_AWLEN   = 8'd0;
        S_AXI_AWVALID = 1'b1;
        check("conc_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = 32'h9ABCDEF0;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WLAST   = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARADDR  = 10'h060;
        S_AXI_ARLEN   = 8'd0;
        S_AXI_ARVALID = 1'b1;
        check("conc_wready", {31'd0, S_AXI_WREADY}, 32'd1);
        check("conc_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_WVALID  = 1'b0;
        S_AXI_WLAST   = 1'b0;
        S_AXI_ARVALID = 1'b0;
        check("conc_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        check("conc_rdata_prewrite", S_AXI_RDATA, 32'h12345678);
        check("conc_rlast", {31'd0, S_AXI_RLAST}, 32'd1);
        check("conc_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        check("conc_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        S_AXI_RREADY = 1'b1;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        S_AXI_BREADY = 1'b0;
        model_write(10'h060 >> 2, 32'h9ABCDEF0, 4'hF);
        check("conc_rvalid_done", {31'd0, S_AXI_RVALID}, 32'd0);
        check("conc_bvalid_done", {31'd0, S_AXI_BVALID}, 32'd0);
        $display("concurrent write/read addr=0x060 checked");
        exp_q.push_back('{32'h9ABCDEF0, 1'b1});
        read_burst(10'h060, 8'd0, -1, 0);

        // Reset in the middle of a write burst.
        S_AXI_AWADDR  = 10'h080;
        S_AXI_AWLEN   = 8'd3;
        S_AXI_AWVALID = 1'b1;
        wait_high(0, "awready_rst");
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            S_AXI_WDATA  = 32'hD00D0000 + i;
            S_AXI_WSTRB  = 4'hF;
            S_AXI_WLAST  = 1'b0;
            S_AXI_WVALID = 1'b1;
            wait_high(1, "wready_rst");
            @(posedge ACLK); #1;
            model_write(32 + i, 32'hD00D0000 + i, 4'hF);
        end
        check("midburst_wready", {31'd0, S_AXI_WREADY}, 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        check_all_zero("midburst_reset");
        S_AXI_WVALID = 1'b0;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        check("post_reset_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        check("post_reset_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        check("post_reset_wready", {31'd0, S_AXI_WREADY}, 32'd0);
        $display("reset mid-burst checked");
        push_expected(10'h010, 8'd3);
        read_burst(10'h010, 8'd3, -1, 0);
        push_expected(10'h080, 8'd1);
        read_burst(10'h080, 8'd1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
